// File: rtl/oam_pkg.sv
// Shared types and constants for the OAM DMA responder and its storage.
package oam_pkg;

    localparam int         OAM_BYTES    = 160;
    localparam logic [7:0] OAM_OPEN_BUS = 8'hFF;
    localparam logic [7:0] OAM_ZERO_BUS = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WRITE,
        DONE
    } oam_state_t;

    // Which value a read port presents on its registered output.
    typedef enum logic [1:0] {
        SRC_RAM,
        SRC_OPEN,
        SRC_ZERO
    } rd_src_t;

endpackage

// File: rtl/oam_ram.sv
// Object attribute storage: one write port and two synchronous read ports (0 = CPU, 1 = PPU).
// Reads return the pre-write contents when a read and write hit the same index in one cycle.
module oam_ram #(
    parameter int DEPTH = 160
) (
    input  logic            clk,
    input  logic            we,
    input  logic [7:0]      waddr,
    input  logic [7:0]      wdata,
    input  logic [1:0]      rd_en,
    input  logic [1:0][7:0] rd_addr,
    output logic [1:0][7:0] rd_q
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
        logic [7:0] q_reg;

        always_ff @(posedge clk) begin
            if (rd_en[gi]) begin
                q_reg <= mem[rd_addr[gi]];
            end
        end

        assign rd_q[gi] = q_reg;
    end

endmodule

// File: rtl/oam_dma_target.sv
// OAM-side DMA responder: captures strobed bytes, commits them to OAM, arbitrates CPU/PPU access.
// Optional sequence checker on dma_idx is built when OAM_DMA_SEQ_CHECK_EN is defined.
module oam_dma_target #(
    parameter int OAM_BYTES = oam_pkg::OAM_BYTES,
    parameter int CNT_W     = 8
) (
    input  logic             clk1,
    input  logic             nreset6,
    input  logic             dma_run,
    input  logic             dma_strobe,
    input  logic [7:0]       dma_idx,
    input  logic [7:0]       dma_d,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [7:0]       cpu_a,
    input  logic [7:0]       cpu_d,
    output logic [7:0]       cpu_do,
    input  logic             ppu_rd,
    input  logic [7:0]       ppu_a,
    output logic [7:0]       ppu_do,
    output logic             oam_busy,
    output logic             dma_done,
    output logic [CNT_W-1:0] dma_count
`ifdef OAM_DMA_SEQ_CHECK_EN
    ,
    output logic             dma_seq_err
`endif
);
    import oam_pkg::*;

    localparam logic [7:0]       IDX_LIMIT = 8'(OAM_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(OAM_BYTES);

    oam_state_t       state_reg, state_next;
    logic             dma_run_q_reg;
    logic [7:0]       cap_idx_reg, cap_data_reg;
    logic [CNT_W-1:0] count_reg;

    logic capture_en, commit_en, start_run;

    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture_en = 1'b0;
        commit_en  = 1'b0;
        start_run  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dma_run && !dma_run_q_reg) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end
            end
            RUN: begin
                if (dma_strobe) begin
                    capture_en = 1'b1;
                    state_next = WRITE;
                end else if (!dma_run) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                commit_en = 1'b1;
                if (dma_strobe) begin
                    capture_en = 1'b1;
                    state_next = WRITE;
                end else if (dma_run) begin
                    state_next = RUN;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (dma_run) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic cap_in_range;
    assign cap_in_range = cap_idx_reg < IDX_LIMIT;

    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6) begin
            dma_run_q_reg <= 1'b0;
            cap_idx_reg   <= 8'h00;
            cap_data_reg  <= 8'h00;
            count_reg     <= '0;
        end else begin
            dma_run_q_reg <= dma_run;
            if (capture_en) begin
                cap_idx_reg  <= dma_idx;
                cap_data_reg <= dma_d;
            end
            if (start_run) begin
                count_reg <= '0;
            end else if (commit_en && cap_in_range && (count_reg != CNT_MAX)) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign oam_busy  = (state_reg != IDLE);
    assign dma_done  = (state_reg == DONE);
    assign dma_count = count_reg;

    // DMA commit owns the write port; CPU writes only land while idle.
    logic       dma_we, cpu_we, ram_we;
    logic [7:0] ram_waddr, ram_wdata;

    assign dma_we    = commit_en && cap_in_range;
    assign cpu_we    = cpu_wr && !oam_busy && (cpu_a < IDX_LIMIT);
    assign ram_we    = dma_we || cpu_we;
    assign ram_waddr = dma_we ? cap_idx_reg  : cpu_a;
    assign ram_wdata = dma_we ? cap_data_reg : cpu_d;

    logic [1:0]      rd_req, rd_en;
    logic [1:0][7:0] rd_addr, rd_q, rd_do;

    assign rd_req  = {ppu_rd, cpu_rd};
    assign rd_addr = {ppu_a, cpu_a};

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_sel
        rd_src_t src_reg;
        logic    in_range;

        assign in_range  = rd_addr[gi] < IDX_LIMIT;
        assign rd_en[gi] = rd_req[gi] && !oam_busy && in_range;

        // Source selection is latched with the request so the output holds between requests.
        always_ff @(posedge clk1 or negedge nreset6) begin
            if (!nreset6) begin
                src_reg <= SRC_OPEN;
            end else if (rd_req[gi]) begin
                if (oam_busy) begin
                    src_reg <= SRC_OPEN;
                end else if (!in_range) begin
                    src_reg <= SRC_ZERO;
                end else begin
                    src_reg <= SRC_RAM;
                end
            end
        end

        assign rd_do[gi] = (src_reg == SRC_RAM)  ? rd_q[gi]     :
                           (src_reg == SRC_ZERO) ? OAM_ZERO_BUS : OAM_OPEN_BUS;
    end

    assign cpu_do = rd_do[0];
    assign ppu_do = rd_do[1];

    oam_ram #(
        .DEPTH (OAM_BYTES)
    ) u_ram (
        .clk     (clk1),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_q    (rd_q)
    );

`ifdef OAM_DMA_SEQ_CHECK_EN
    logic [7:0] exp_idx_reg;
    logic       seq_err_reg;

    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6) begin
            exp_idx_reg <= 8'h00;
            seq_err_reg <= 1'b0;
        end else begin
            if (start_run) begin
                exp_idx_reg <= 8'h00;
            end else if (capture_en) begin
                exp_idx_reg <= exp_idx_reg + 8'd1;
            end
            // Sticky across back-to-back transfers; only a fresh start from IDLE clears it.
            if (start_run && (state_reg == IDLE)) begin
                seq_err_reg <= 1'b0;
            end else if (capture_en && (dma_idx != exp_idx_reg)) begin
                seq_err_reg <= 1'b1;
            end
        end
    end

    assign dma_seq_err = seq_err_reg;
`endif

endmodule
